match_scoreboard: RTL
=====================

Name: match_scoreboard

Overview:
Downstream of the nine-light playfield in the tug-of-war top level. It detects round wins from the end-light states and the conditioned single-cycle press pulses, and keeps per-side scores. It drives the two score digits (HEX1 = left/cyber, HEX0 = right/human) and pulses next_round after a hold delay so the playfield can recentre. The match ends when either side reaches WIN_SCORE.

Parameters:
WIN_SCORE, 7, score that ends the match; legal range 1..9.
HOLD_CYCLES, 4, clk cycles spent in HOLD between a round win and the next_round pulse; must be >= 1. Board builds use a larger value.
SCORE_W, 4, score register width; fixed, covers 0..9.

Ports:
clk  input  1  system clock (CLOCK_50 in sim, divided clock on board)
reset  input  1  asynchronous, active-low reset; block is in reset while reset==0
L  input  1  left (cyber) press pulse, one cycle per press, already synchronised
R  input  1  right (human) press pulse, one cycle per press, already synchronised
left_end  input  1  leftmost playfield light (LEDR[9]) lit
right_end  input  1  rightmost playfield light (LEDR[1]) lit
next_round  output  1  one-cycle pulse; playfield returns to centre
hex1  output  7  active-low 7-seg, left score
hex0  output  7  active-low 7-seg, right score
match_over  output  1  high once a side reaches WIN_SCORE
winner_left  output  1  valid when match_over; 1 = left won, 0 = right won

Behaviour:
- Reset (reset==0, async): state=PLAY, left_score=0, right_score=0, hold counter=0, next_round=0, match_over=0, winner_left=0, hex0=hex1=7'b1000000 ("0").
- Win qualify (PLAY only): left_win = left_end & L & ~R; right_win = right_end & R & ~L. A press on both sides in the same cycle cancels: no win.
- Both left_win and right_win cannot be true at once. If both end inputs are high with a lone press, only the pressed side's rule applies.
- PLAY:
  - On posedge with left_win: left_score+1.
  - On posedge with right_win: right_score+1.
  - If the new score == WIN_SCORE, go to MATCH_OVER. Otherwise load the hold counter with HOLD_CYCLES-1 and go to HOLD.
  - The score register and the hex output update on that same edge.
- HOLD:
  - All L/R/end inputs are ignored.
  - The counter decrements each cycle.
  - On the edge where the counter==0: state goes to PLAY and next_round is registered to 1.
  - next_round is high for exactly one cycle, which is the first PLAY cycle.
  - Latency: win edge t0 -> next_round high in the cycle following edge t0+HOLD_CYCLES.
- next_round is never asserted outside the HOLD->PLAY transition and never in MATCH_OVER.
- MATCH_OVER:
  - Absorbing state; only reset leaves it.
  - match_over=1. winner_left is latched on the entry edge.
  - Scores are frozen and the inputs are ignored.
- Scores never exceed WIN_SCORE and never wrap.
- A win during PLAY in the same cycle that next_round is high is legal and counts.
- Hex encoding (active-low gfedcba), combinational from the score registers:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other value = 1111111
- Reset asserted mid-HOLD or mid-pulse: next_round drops immediately and all state returns to the reset values.

Decomposition:
- Package tow_pkg holds:
  - typedef enum logic [1:0] {PLAY, HOLD, MATCH_OVER} sb_state_t
  - the ten SEG_n 7-bit constants plus SEG_BLANK
- Sub-module seg7_digit: 4-bit value in, 7-bit active-low segments out. Instantiated twice; the playfield team can reuse it.

Test Plan:
- Reset low then high; right_end=1 with one R pulse -> right_score=1 and hex0=1111001 on that edge; next_round=1 for exactly one cycle, 4 cycles later (HOLD_CYCLES=4); hex1 stays 1000000.
- left_end=1 with L and R pulsed in the same cycle -> no score change, state remains PLAY, next_round stays 0.
- During HOLD: pulse L with left_end=1, and R with right_end=1 -> both ignored; scores unchanged; next_round still fires on schedule.
- Seven left wins (WIN_SCORE=7) -> hex1=1111000, match_over=1, winner_left=1, no 7th next_round pulse; further L pulses leave all outputs unchanged.
- Drive reset=0 asynchronously (between edges) two cycles into HOLD -> outputs go to reset values immediately, without waiting for the next clock edge; after release, the first right win gives right_score=1.
- Win in the same cycle that next_round is high -> win counts; a second next_round pulse follows HOLD_CYCLES later.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared types and seven-segment glyphs for the tug-of-war match logic.
// Segment constants are active-low, bit order gfedcba.
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    HOLD       = 2'd1,
    MATCH_OVER = 2'd2
  } sb_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_digit.sv
// Decimal digit to active-low seven-segment pattern; out-of-range values blank.
module seg7_digit
  import tow_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/match_scoreboard.sv
// Round-win detection, per-side scoring, hold-then-recentre pulse and match end.
// Scores and digits update on the win edge; next_round fires HOLD_CYCLES edges later.
module match_scoreboard
  import tow_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4,
  parameter int SCORE_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       left_end,
  input  logic       right_end,
  output logic       next_round,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       match_over,
  output logic       winner_left
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  sb_state_t          state;
  logic [SCORE_W-1:0] left_score;
  logic [SCORE_W-1:0] right_score;
  logic [HOLD_W-1:0]  hold_cnt;

  logic               left_win;
  logic               right_win;
  logic [SCORE_W-1:0] left_inc;
  logic [SCORE_W-1:0] right_inc;

  // Simultaneous presses cancel, so at most one of these is ever set.
  assign left_win  = left_end  & L & ~R;
  assign right_win = right_end & R & ~L;
  assign left_inc  = left_score  + SCORE_W'(1);
  assign right_inc = right_score + SCORE_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= PLAY;
      left_score  <= '0;
      right_score <= '0;
      hold_cnt    <= '0;
      next_round  <= 1'b0;
      match_over  <= 1'b0;
      winner_left <= 1'b0;
    end else begin
      next_round <= 1'b0;
      case (state)
        PLAY: begin
          if (left_win) begin
            left_score <= left_inc;
            if (left_inc == WIN_VAL) begin
              state       <= MATCH_OVER;
              match_over  <= 1'b1;
              winner_left <= 1'b1;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end else if (right_win) begin
            right_score <= right_inc;
            if (right_inc == WIN_VAL) begin
              state       <= MATCH_OVER;
              match_over  <= 1'b1;
              winner_left <= 1'b0;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state      <= PLAY;
            next_round <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        MATCH_OVER: begin
          state <= MATCH_OVER;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

  seg7_digit u_left_digit (
    .value (left_score),
    .seg   (hex1)
  );

  seg7_digit u_right_digit (
    .value (right_score),
    .seg   (hex0)
  );

endmodule
